// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus widths, register offsets, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int REG_OFF_W = 4;

    localparam logic [REG_OFF_W-1:0] INT_PEND   = 4'h0;
    localparam logic [REG_OFF_W-1:0] INT_MASK   = 4'h1;
    localparam logic [REG_OFF_W-1:0] INT_STAT   = 4'h2;
    localparam logic [REG_OFF_W-1:0] INT_GIE    = 4'h3;
    localparam logic [REG_OFF_W-1:0] INT_SWTRIG = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 wins over all higher indices.
// Latency: purely combinational.
// Backpressure: none.
module int_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               vld
);

    // Scan from the top down so the lowest set index is the last one assigned.
    always_comb begin
        id  = '0;
        vld = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id  = ID_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge-latched pends, mask/global enable, IDLE/REQ/SERVICE handshake, no nesting.
// Latency: source edge at clock k sets PEND at k, irq/int_vec registered after k+1; rdata one cycle after a read.
// Backpressure: none; bus accesses always complete, pends accumulate while an interrupt is in service.
// Optional: define INT_SWTRIG_EN to map a write-only software trigger register at offset 0x4.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                NUM_SRC    = 4,
    parameter logic [DATA_W-1:0] VEC_BASE   = 16'h0010,
    parameter logic [DATA_W-1:0] VEC_STRIDE = 16'h0004
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic                 ctrl,
    input  logic [REG_OFF_W-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    input  logic [NUM_SRC-1:0]   int_src,
    output logic                 irq,
    output logic [DATA_W-1:0]    int_vec,
    input  logic                 int_ack,
    input  logic                 int_ret
);

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    int_state_t           state_q, state_d;
    logic [NUM_SRC-1:0]   src_q, src_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic                 gie_q, gie_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 irq_q, irq_d;
    logic [DATA_W-1:0]    int_vec_q, int_vec_d;

    logic                 bus_wr;
    logic                 bus_rd;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   sw_set;
    logic [NUM_SRC-1:0]   pend_masked;
    logic [ID_W-1:0]      enc_id;
    logic                 enc_vld;
    logic                 ack_take;
    logic [DATA_W-1:0]    stat_word;

    // Upper write-data bits beyond the source count have no register behind them.
    logic                 unused_wdata;
    assign unused_wdata = ^wdata;

    assign bus_wr      = EN & ctrl;
    assign bus_rd      = EN & ~ctrl;
    assign rise        = int_src & ~src_q;
    assign pend_masked = pend_q & mask_q;
    assign ack_take    = (state_q == ST_REQ) && int_ack;

    int_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req (pend_masked),
        .id  (enc_id),
        .vld (enc_vld)
    );

    // Software trigger: a write-1 behaves exactly like a hardware rising edge.
    always_comb begin
        sw_set = '0;
`ifdef INT_SWTRIG_EN
        if (bus_wr && (addr == INT_SWTRIG)) begin
            sw_set = wdata[NUM_SRC-1:0];
        end
`endif
    end

    // Register-file updates: clears are applied first so that a same-cycle set always wins.
    always_comb begin
        src_d  = int_src;
        mask_d = mask_q;
        gie_d  = gie_q;
        pend_d = pend_q;
        if (bus_wr && (addr == INT_PEND)) begin
            pend_d = pend_d & ~wdata[NUM_SRC-1:0];
        end
        if (ack_take) begin
            pend_d[id_q] = 1'b0;
        end
        pend_d = pend_d | rise | sw_set;
        if (bus_wr && (addr == INT_MASK)) begin
            mask_d = wdata[NUM_SRC-1:0];
        end
        if (bus_wr && (addr == INT_GIE)) begin
            gie_d = wdata[0];
        end
    end

    // Handshake FSM: id is latched on IDLE->REQ and frozen until the next arbitration.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && enc_vld) begin
                    state_d = ST_REQ;
                    id_d    = enc_id;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end else if (!gie_q || !pend_masked[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_ret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered CPU-facing outputs follow the next state and the next id.
    always_comb begin
        irq_d     = (state_d == ST_REQ);
        int_vec_d = VEC_BASE + (DATA_W'(id_d) * VEC_STRIDE);
    end

    // Read mux; unmapped offsets (and the write-only trigger) return zero.
    always_comb begin
        stat_word            = '0;
        stat_word[15]        = (state_q == ST_SERVICE);
        stat_word[ID_W-1:0]  = id_q;
        rdata_d              = rdata_q;
        if (bus_rd) begin
            case (addr)
                INT_PEND: rdata_d = DATA_W'(pend_q);
                INT_MASK: rdata_d = DATA_W'(mask_q);
                INT_STAT: rdata_d = stat_word;
                INT_GIE:  rdata_d = DATA_W'(gie_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    // State register; reset overrides every other input on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            id_q      <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            int_vec_q <= VEC_BASE;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            id_q      <= id_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            int_vec_q <= int_vec_d;
        end
    end

    assign rdata   = rdata_q;
    assign irq     = irq_q;
    assign int_vec = int_vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: reset, handshake, priority, no-nesting, masking/W1C, GIE drop, reset mid-service.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic        ctrl;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  int_src;
    logic        irq;
    logic [15:0] int_vec;
    logic        int_ack;
    logic        int_ret;

    int checks = 0;
    int errors = 0;

    int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .EN      (EN),
        .ctrl    (ctrl),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_src (int_src),
        .irq     (irq),
        .int_vec (int_vec),
        .int_ack (int_ack),
        .int_ret (int_ret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        EN = 1'b1; ctrl = 1'b1; addr = a; wdata = d;
        tick();
        EN = 1'b0; ctrl = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
        EN = 1'b1; ctrl = 1'b0; addr = a;
        tick();
        EN = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1; EN = 1'b0; ctrl = 1'b0; addr = '0; wdata = '0;
        int_src = '0; int_ack = 1'b0; int_ret = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        checks++; if (int_vec !== 16'h0010) begin errors++; $display("FAIL reset_vec got=%h exp=0010", int_vec); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_pend got=%h exp=0000", d); end
        bus_rd(4'h1, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_mask got=%h exp=0000", d); end
        bus_rd(4'h2, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_stat got=%h exp=0000", d); end
    endtask

    task automatic test_handshake();
        logic [15:0] d;
        bus_wr(4'h1, 16'h0003);
        bus_wr(4'h3, 16'h0001);
        int_src = 4'b0010;
        tick();  // edge k: PEND[1] set
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hs_irq_at_pend got=%0b exp=0", irq); end
        tick();  // edge k+1: REQ
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hs_irq got=%0b exp=1", irq); end
        checks++; if (int_vec !== 16'h0014) begin errors++; $display("FAIL hs_vec got=%h exp=0014", int_vec); end
        pulse_ack();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hs_irq_after_ack got=%0b exp=0", irq); end
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL hs_pend_after_ack got=%h exp=0000", d); end
        bus_rd(4'h2, d);
        checks++; if (d !== 16'h8001) begin errors++; $display("FAIL hs_stat_service got=%h exp=8001", d); end
        pulse_ret();
        bus_rd(4'h2, d);
        checks++; if (d[15] !== 1'b0) begin errors++; $display("FAIL hs_stat_idle got=%0b exp=0", d[15]); end
        int_src = 4'b0000;
        tick();
    endtask

    task automatic test_priority();
        int_src = 4'b0011;
        tick(); tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq0 got=%0b exp=1", irq); end
        checks++; if (int_vec !== 16'h0010) begin errors++; $display("FAIL prio_vec0 got=%h exp=0010", int_vec); end
        pulse_ack();
        pulse_ret();   // back in IDLE; source 1 still pending
        tick();        // IDLE re-arbitrates on the next edge
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq1 got=%0b exp=1", irq); end
        checks++; if (int_vec !== 16'h0014) begin errors++; $display("FAIL prio_vec1 got=%h exp=0014", int_vec); end
        pulse_ack();
        pulse_ret();
        int_src = 4'b0000;
        tick();
    endtask

    task automatic test_no_nesting();
        int_src = 4'b0010;
        tick(); tick();
        pulse_ack();   // SERVICE for id 1
        int_src = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nest_irq_in_service cyc=%0d got=%0b exp=0", i, irq); end
        end
        pulse_ret();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nest_irq_at_ret got=%0b exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL nest_irq_after_ret got=%0b exp=1", irq); end
        checks++; if (int_vec !== 16'h0010) begin errors++; $display("FAIL nest_vec got=%h exp=0010", int_vec); end
        pulse_ack();
        pulse_ret();
        int_src = 4'b0000;
        tick();
    endtask

    task automatic test_mask_w1c();
        logic [15:0] d;
        bus_wr(4'h1, 16'h0000);
        int_src = 4'b0100;
        tick(); tick();
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL mask_pend got=%h exp=0004", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq got=%0b exp=0", irq); end
        int_src = 4'b0000;
        tick();
        int_src = 4'b0100;      // new edge in the same cycle as the W1C
        bus_wr(4'h0, 16'h0004);
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL w1c_set_wins got=%h exp=0004", d); end
        bus_wr(4'h0, 16'h0004); // plain clear, no edge
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL w1c_clear got=%h exp=0000", d); end
        bus_wr(4'h7, 16'hFFFF);
        bus_rd(4'h7, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read got=%h exp=0000", d); end
        int_src = 4'b0000;
        tick();
    endtask

    task automatic test_gie_drop();
        logic [15:0] d;
        bus_wr(4'h1, 16'h0002);
        int_src = 4'b0010;
        tick(); tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL gie_irq_before got=%0b exp=1", irq); end
        bus_wr(4'h3, 16'h0000);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL gie_drop_irq got=%0b exp=0", irq); end
        pulse_ack();            // ack outside REQ is ignored
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL ack_ignored_pend got=%h exp=0002", d); end
        bus_wr(4'h0, 16'h000F);
        bus_wr(4'h3, 16'h0001);
        int_src = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_service();
        logic [15:0] d;
        bus_wr(4'h1, 16'h0009);
        int_src = 4'b0001;
        tick(); tick();
        pulse_ack();
        int_src = 4'b1001;
        tick();
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0008) begin errors++; $display("FAIL rms_pend_before got=%h exp=0008", d); end
        rst = 1'b1; int_src = 4'b0000;
        tick();
        rst = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rms_irq got=%0b exp=0", irq); end
        checks++; if (int_vec !== 16'h0010) begin errors++; $display("FAIL rms_vec got=%h exp=0010", int_vec); end
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rms_pend got=%h exp=0000", d); end
        bus_rd(4'h1, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rms_mask got=%h exp=0000", d); end
        bus_rd(4'h2, d);
        checks++; if (d[15] !== 1'b0) begin errors++; $display("FAIL rms_stat got=%0b exp=0", d[15]); end
    endtask

    task automatic test_swtrig();
        logic [15:0] d;
        bus_wr(4'h1, 16'h000F);
        bus_wr(4'h3, 16'h0001);
`ifdef INT_SWTRIG_EN
        bus_wr(4'h4, 16'h0004);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sw_irq_at_pend got=%0b exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sw_irq got=%0b exp=1", irq); end
        checks++; if (int_vec !== 16'h0018) begin errors++; $display("FAIL sw_vec got=%h exp=0018", int_vec); end
        bus_rd(4'h4, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sw_read got=%h exp=0000", d); end
        pulse_ack();
        pulse_ret();
`else
        bus_wr(4'h4, 16'h0004);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sw_off_irq got=%0b exp=0", irq); end
        bus_rd(4'h0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sw_off_pend got=%h exp=0000", d); end
        bus_rd(4'h4, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sw_off_read got=%h exp=0000", d); end
`endif
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_priority();
        test_no_nesting();
        test_mask_w1c();
        test_gie_drop();
        test_reset_mid_service();
        test_swtrig();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
